// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master one-slave bus arbiter with release phase; `define BUS_ARBITER_TIMEOUT_EN adds an ACTIVE timeout abort
module bus_arbiter #(
    parameter bit FIXED_PRIORITY = 1'b0,
    parameter int TIMEOUT        = 1024
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_m0_request,
    input  logic        i_m0_rw,
    input  logic [31:0] i_m0_address,
    input  logic [31:0] i_m0_wdata,
    output logic [31:0] o_m0_rdata,
    output logic        o_m0_ready,
    input  logic        i_m1_request,
    input  logic        i_m1_rw,
    input  logic [31:0] i_m1_address,
    input  logic [31:0] i_m1_wdata,
    output logic [31:0] o_m1_rdata,
    output logic        o_m1_ready,
    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    output logic        o_busy,
    output logic        o_timeout
);
    localparam logic [1:0] IDLE = 2'd0, ACTIVE = 2'd1, RELEASE = 2'd2;
    logic [1:0]  state;
    logic        grant, last, active, pick, expire;
    logic        sel_request, sel_rw, ready_g, rw_q;
    logic [31:0] sel_address, sel_wdata, rdata_g, address_q, wdata_q, m0_rdata_q, m1_rdata_q;

    assign active      = state == ACTIVE;
    assign sel_request = grant ? i_m1_request : i_m0_request;
    assign sel_rw      = grant ? i_m1_rw : i_m0_rw;
    assign sel_address = grant ? i_m1_address : i_m0_address;
    assign sel_wdata   = grant ? i_m1_wdata : i_m0_wdata;
    // master 1 wins when alone, or on a tie under round-robin when master 0 went last
    assign pick        = i_m1_request && (!i_m0_request || (!FIXED_PRIORITY && !last));

`ifdef BUS_ARBITER_TIMEOUT_EN
    logic [31:0] count;
    logic        timeout_q;
    assign expire    = active && count == 32'(TIMEOUT);
    assign o_timeout = timeout_q;
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count     <= '0;
            timeout_q <= 1'b0;
        end else begin
            count     <= active ? count + {31'd0, !i_bus_ready} : '0;
            timeout_q <= timeout_q | expire;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
    assign expire         = 1'b0;
    assign o_timeout      = 1'b0;
`endif

    assign ready_g       = expire | i_bus_ready;
    assign rdata_g       = expire ? 32'hffff_ffff : i_bus_rdata;
    assign o_bus_request = active && sel_request && !expire;
    assign o_bus_rw      = active ? sel_rw : rw_q;
    assign o_bus_address = active ? sel_address : address_q;
    assign o_bus_wdata   = active ? sel_wdata : wdata_q;
    assign o_m0_ready    = active && !grant && ready_g;
    assign o_m1_ready    = active && grant && ready_g;
    assign o_m0_rdata    = (active && !grant) ? rdata_g : m0_rdata_q;
    assign o_m1_rdata    = (active && grant) ? rdata_g : m1_rdata_q;
    assign o_busy        = state != IDLE;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last       <= 1'b1;
            rw_q       <= 1'b0;
            address_q  <= '0;
            wdata_q    <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            if (state == IDLE && (i_m0_request || i_m1_request)) begin
                state <= ACTIVE;
                grant <= pick;
            end
            if (active) begin
                rw_q      <= sel_rw;
                address_q <= sel_address;
                wdata_q   <= sel_wdata;
                if (grant) m1_rdata_q <= rdata_g;
                else m0_rdata_q <= rdata_g;
                if (!sel_request || expire) begin
                    state <= RELEASE;
                    last  <= grant;
                end
            end
            // hold off the next grant until the slave has dropped its ready
            if (state == RELEASE && !i_bus_ready) state <= IDLE;
            if (state == 2'd3) state <= IDLE;
        end
    end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Two-master, one-slave arbiter for the system bus. Master 0 is the CPU data port; master 1 is the DMA bus port. It grants the shared slave bus to one master at a time and holds the grant for a whole request/ready transaction. It also enforces a release phase so a stale slave ready is never seen by the next master.

Parameters:
FIXED_PRIORITY, 0, 0 = round-robin between masters; 1 = master 0 always wins simultaneous requests
TIMEOUT, 1024, cycles in ACTIVE without i_bus_ready before abort (used only with BUS_ARBITER_TIMEOUT_EN)

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous active-high reset
i_m0_request  in  1  master 0 request, held until ready seen
i_m0_rw  in  1  master 0 read(0)/write(1)
i_m0_address  in  32  master 0 address
i_m0_wdata  in  32  master 0 write data
o_m0_rdata  out  32  master 0 read data
o_m0_ready  out  1  master 0 ready
i_m1_request  in  1  master 1 request
i_m1_rw  in  1  master 1 read/write
i_m1_address  in  32  master 1 address
i_m1_wdata  in  32  master 1 write data
o_m1_rdata  out  32  master 1 read data
o_m1_ready  out  1  master 1 ready
o_bus_request  out  1  slave request
o_bus_rw  out  1  slave read/write
o_bus_address  out  32  slave address
o_bus_wdata  out  32  slave write data
i_bus_ready  in  1  slave ready; slave deasserts it after request drops
i_bus_rdata  in  32  slave read data
o_busy  out  1  high whenever state != IDLE
o_timeout  out  1  sticky timeout flag (feature only; tied 0 otherwise)

Behaviour:
- Clock and reset: one clock, i_clock. i_reset is synchronous and active-high.
- Reset: state=IDLE, grant=0, last=1. All outputs 0: o_bus_*, o_mX_ready, o_mX_rdata, o_busy, o_timeout.
- States: IDLE, ACTIVE, RELEASE. grant is a 1-bit register; last is the master that finished most recently.
- IDLE:
  - If only one master requests, grant it and go to ACTIVE.
  - If both request and FIXED_PRIORITY=0, grant !last. If FIXED_PRIORITY=1, grant 0.
  - If none request, stay in IDLE.
- ACTIVE:
  - Slave outputs combinationally mux from the granted master: o_bus_request = granted request, plus its rw, address and wdata.
  - Outside ACTIVE, o_bus_request=0 and the other slave outputs hold their last value.
  - Granted master: o_mX_ready = i_bus_ready and o_mX_rdata = i_bus_rdata, combinationally.
  - Non-granted master: ready=0 and rdata holds.
  - When the granted request is 0, set last=grant and go to RELEASE. This covers both normal completion and an abort before ready.
- RELEASE: stay until i_bus_ready==0, then go to IDLE. Both master readies are forced to 0 in RELEASE.
- Latency:
  - Request at edge N to o_bus_request high after edge N+1.
  - Back-to-back transactions for the same master need at least 1 idle cycle: RELEASE then IDLE.
- A non-granted request is held pending and has no effect until IDLE. A pending master is served next under round-robin, so there is no starvation.
- Reset asserted mid-transaction: outputs drop the following cycle. The slave is expected to abandon the access when its request drops.
- The arbiter makes no address decode and no data modification.

Optional Feature:
- Macro: BUS_ARBITER_TIMEOUT_EN.
- When defined:
  - A 32-bit counter clears on entry to ACTIVE and increments each ACTIVE cycle with i_bus_ready=0.
  - When it reaches TIMEOUT, the arbiter forces o_bus_request=0 and pulses ready=1 for one cycle to the granted master, with rdata=32'hffff_ffff.
  - It sets o_timeout (sticky until reset), sets last=grant and goes to RELEASE.
- When undefined: no counter, o_timeout tied 0, and ACTIVE waits indefinitely.

Test Plan:
- M0 write 0x1000 := 0xCAFEBABE, slave ready after 3 cycles -> bus sees request/rw=1/addr/wdata exactly from cycle after request; o_m0_ready mirrors i_bus_ready; M1 ready stays 0.
- M0 and M1 request in the same cycle after reset, FIXED_PRIORITY=0 -> M0 granted first (last=1), M1 granted after RELEASE. Repeat -> M1 then M0 alternation.
- FIXED_PRIORITY=1, M0 issues 4 back-to-back reads while M1 is pending -> M0 is granted each time; M1 is granted only when M0 is idle in IDLE.
- Slave holds i_bus_ready high 2 cycles after request drops -> arbiter stays in RELEASE; M1 pending sees no ready until the new grant; no stale ready reaches M1.
- M1 drops request mid-ACTIVE before ready -> RELEASE then IDLE; o_bus_request falls the same cycle; the next grant proceeds normally.
- BUS_ARBITER_TIMEOUT_EN, TIMEOUT=16, slave never readies -> after 16 ACTIVE cycles M0 sees ready=1 with rdata=0xFFFFFFFF for 1 cycle; o_timeout=1 until i_reset.
